// File: rtl/accelerator_matrix_stream_feeder.sv
// rtl/accelerator_matrix_stream_feeder.sv - buffers a row-major matrix, then replays it one element per downstream request
module accelerator_matrix_stream_feeder #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int DEPTH        = 64,
    parameter int ADDR_SIZE    = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 DATA_IN_ENABLE,
    input  logic                 NEXT_IN,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic                 DATA_OUT_MATRIX_ENABLE,
    output logic                 DATA_OUT_VECTOR_ENABLE,
    output logic                 DATA_OUT_SCALAR_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int TOTAL_W = 2 * DATA_SIZE;
    localparam logic [TOTAL_W-1:0] DEPTH_W = TOTAL_W'(DEPTH);

    if (CONTROL_SIZE < 1 || (1 << ADDR_SIZE) != DEPTH) begin : g_param_check
        $error("accelerator_matrix_stream_feeder: inconsistent DEPTH/ADDR_SIZE/CONTROL_SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE-1:0] row_i;
    logic [ADDR_SIZE-1:0] col_j;
    logic [ADDR_SIZE-1:0] last_idx;
    logic [DATA_SIZE-1:0] size_j_q;
    logic                 err_q;

    logic [TOTAL_W-1:0]   total_w;
    logic                 size_bad;
    logic                 wr_last;
    logic                 rd_last;
    logic                 col_last;

    // Full-width product so huge sizes cannot alias into a small legal total.
    assign total_w  = {{DATA_SIZE{1'b0}}, SIZE_I_IN} * {{DATA_SIZE{1'b0}}, SIZE_J_IN};
    assign size_bad = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (total_w > DEPTH_W);
    assign wr_last  = (wr_ptr == last_idx);
    assign rd_last  = (rd_ptr == last_idx);
    assign col_last = (DATA_SIZE'(col_j) == size_j_q - DATA_SIZE'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_next = size_bad ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (DATA_IN_ENABLE && wr_last) begin
                    state_next = S_EMIT;
                end
            end
            S_EMIT: state_next = S_WAIT;
            S_WAIT: begin
                if (rd_last) begin
                    state_next = S_DONE;
                end else if (NEXT_IN) begin
                    state_next = S_EMIT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Buffer storage is not reset; only written locations are ever read.
    always_ff @(posedge CLK) begin
        if (state == S_LOAD && DATA_IN_ENABLE) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READY                  <= 1'b0;
            ERROR                  <= 1'b0;
            DATA_OUT_MATRIX_ENABLE <= 1'b0;
            DATA_OUT_VECTOR_ENABLE <= 1'b0;
            DATA_OUT_SCALAR_ENABLE <= 1'b0;
            DATA_OUT               <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            row_i                  <= '0;
            col_j                  <= '0;
            last_idx               <= '0;
            size_j_q               <= '0;
            err_q                  <= 1'b0;
        end else begin
            READY                  <= 1'b0;
            ERROR                  <= 1'b0;
            DATA_OUT_MATRIX_ENABLE <= 1'b0;
            DATA_OUT_VECTOR_ENABLE <= 1'b0;
            DATA_OUT_SCALAR_ENABLE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        size_j_q <= SIZE_J_IN;
                        last_idx <= total_w[ADDR_SIZE-1:0] - ADDR_SIZE'(1);
                        err_q    <= size_bad;
                        wr_ptr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (DATA_IN_ENABLE) begin
                        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
                        if (wr_last) begin
                            rd_ptr <= '0;
                            row_i  <= '0;
                            col_j  <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    DATA_OUT               <= mem[rd_ptr];
                    DATA_OUT_SCALAR_ENABLE <= 1'b1;
                    DATA_OUT_MATRIX_ENABLE <= (row_i == '0) && (col_j == '0);
                    DATA_OUT_VECTOR_ENABLE <= (col_j == '0);
                end
                S_WAIT: begin
                    if (NEXT_IN && !rd_last) begin
                        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
                        if (col_last) begin
                            col_j <= '0;
                            row_i <= row_i + ADDR_SIZE'(1);
                        end else begin
                            col_j <= col_j + ADDR_SIZE'(1);
                        end
                    end
                end
                S_DONE: begin
                    READY <= 1'b1;
                    ERROR <= err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_matrix_stream_feeder.sv
// tb/tb_accelerator_matrix_stream_feeder.sv - randomized self-checking bench for accelerator_matrix_stream_feeder
module tb_accelerator_matrix_stream_feeder;

    localparam int DATA_SIZE = 64;
    localparam int DEPTH     = 64;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 START;
    logic                 READY;
    logic                 ERROR;
    logic                 DATA_IN_ENABLE;
    logic                 NEXT_IN;
    logic [DATA_SIZE-1:0] SIZE_I_IN;
    logic [DATA_SIZE-1:0] SIZE_J_IN;
    logic [DATA_SIZE-1:0] DATA_IN;
    logic                 DATA_OUT_MATRIX_ENABLE;
    logic                 DATA_OUT_VECTOR_ENABLE;
    logic                 DATA_OUT_SCALAR_ENABLE;
    logic [DATA_SIZE-1:0] DATA_OUT;

    int checks   = 0;
    int failures = 0;
    logic [DATA_SIZE-1:0] model_out;

    accelerator_matrix_stream_feeder dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .START                  (START),
        .READY                  (READY),
        .ERROR                  (ERROR),
        .DATA_IN_ENABLE         (DATA_IN_ENABLE),
        .NEXT_IN                (NEXT_IN),
        .SIZE_I_IN              (SIZE_I_IN),
        .SIZE_J_IN              (SIZE_J_IN),
        .DATA_IN                (DATA_IN),
        .DATA_OUT_MATRIX_ENABLE (DATA_OUT_MATRIX_ENABLE),
        .DATA_OUT_VECTOR_ENABLE (DATA_OUT_VECTOR_ENABLE),
        .DATA_OUT_SCALAR_ENABLE (DATA_OUT_SCALAR_ENABLE),
        .DATA_OUT               (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, DATA_OUT, 64'd0);
        check({tag, "_scalar"}, DATA_OUT_SCALAR_ENABLE, 1'b0);
        check({tag, "_vector"}, DATA_OUT_VECTOR_ENABLE, 1'b0);
        check({tag, "_matrix"}, DATA_OUT_MATRIX_ENABLE, 1'b0);
        check({tag, "_ready"}, READY, 1'b0);
        check({tag, "_error"}, ERROR, 1'b0);
    endtask

    // One run from START to READY, modelled from the cycle rules only:
    // first element 2 cycles after the last accepted load, each further element
    // 2 cycles after the first NEXT_IN seen at/after the previous emit,
    // READY 2 cycles after the last emit (or after START for rejected sizes).
    task automatic run(input logic [63:0] rows, input logic [63:0] cols,
                       input int gap_pct, input int next_pct, input int data_mode,
                       input int hold, input int abort_at);
        logic [63:0] data_q[$];
        bit   bad;
        bit   done;
        bit   waiting;
        bit   exp_scalar;
        int   total;
        int   cols_i;
        int   loaded;
        int   emitted;
        int   cyc;
        int   exp_emit;
        int   exp_ready;
        int   hold_left;
        int   budget;

        bad = (rows == 0) || (cols == 0) || (rows > DEPTH) || (cols > DEPTH) ||
              (rows * cols > DEPTH);
        total     = bad ? 0 : int'(rows * cols);
        cols_i    = bad ? 1 : int'(cols);
        loaded    = 0;
        emitted   = 0;
        cyc       = 0;
        exp_emit  = -1;
        exp_ready = bad ? 2 : -1;
        hold_left = 0;
        waiting   = 1'b0;
        done      = 1'b0;
        budget    = 40 * total + 60;
        for (int k = 0; k < total; k++) begin
            case (data_mode)
                1:       data_q.push_back(64'(k + 1));
                2:       data_q.push_back(64'(10 * (k + 1)));
                default: data_q.push_back(rand64());
            endcase
        end

        START          = 1'b1;
        SIZE_I_IN      = rows;
        SIZE_J_IN      = cols;
        DATA_IN_ENABLE = 1'($urandom_range(0, 1));
        DATA_IN        = rand64();
        NEXT_IN        = 1'($urandom_range(0, 1));

        while (!done && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (abort_at != 0 && emitted == abort_at - 1 && cyc == exp_emit - 1) begin
                START = 1'b0;
                DATA_IN_ENABLE = 1'b0;
                NEXT_IN = 1'b1;
                RST = 1'b0;
                #1;
                check_outputs_zero("abort");
                model_out = '0;
                repeat (3) @(posedge CLK);
                #1;
                RST = 1'b1;
                repeat (6) begin
                    @(posedge CLK);
                    #1;
                    check("post_abort_ready", READY, 1'b0);
                    check("post_abort_scalar", DATA_OUT_SCALAR_ENABLE, 1'b0);
                end
                NEXT_IN = 1'b0;
                return;
            end
            exp_scalar = (cyc == exp_emit);
            check("scalar", DATA_OUT_SCALAR_ENABLE, exp_scalar);
            if (exp_scalar) begin
                model_out = data_q[emitted];
                check("matrix", DATA_OUT_MATRIX_ENABLE, emitted == 0);
                check("vector", DATA_OUT_VECTOR_ENABLE, (emitted % cols_i) == 0);
                emitted++;
                waiting   = (emitted < total);
                hold_left = (emitted == 1) ? hold : 0;
                if (emitted == total) exp_ready = cyc + 2;
            end else begin
                check("matrix_idle", DATA_OUT_MATRIX_ENABLE, 1'b0);
                check("vector_idle", DATA_OUT_VECTOR_ENABLE, 1'b0);
            end
            check("data_out", DATA_OUT, model_out);
            check("ready", READY, cyc == exp_ready);
            check("error", ERROR, (cyc == exp_ready) && bad);

            if (cyc == exp_ready) begin
                done = 1'b1;
                START = 1'b0;
                DATA_IN_ENABLE = 1'b0;
                NEXT_IN = 1'b0;
            end else begin
                START     = ($urandom_range(0, 99) < 10);
                SIZE_I_IN = 64'($urandom_range(0, 3));
                SIZE_J_IN = 64'($urandom_range(0, 3));
                DATA_IN_ENABLE = ($urandom_range(0, 99) >= gap_pct);
                if (DATA_IN_ENABLE && loaded < total) begin
                    DATA_IN = data_q[loaded];
                    loaded++;
                    if (loaded == total) exp_emit = cyc + 2;
                end else begin
                    DATA_IN = rand64();
                end
                if (hold_left > 0) begin
                    NEXT_IN = 1'b0;
                    hold_left--;
                end else begin
                    NEXT_IN = ($urandom_range(0, 99) < next_pct);
                end
                if (waiting && NEXT_IN) begin
                    waiting  = 1'b0;
                    exp_emit = cyc + 2;
                end
            end
        end

        if (!done) begin
            check("ready_seen", done, 1'b1);
            START = 1'b0;
            DATA_IN_ENABLE = 1'b0;
            NEXT_IN = 1'b0;
        end else if (!bad && gap_pct == 0 && next_pct == 100 && hold == 0) begin
            check("run_latency", cyc, 3 * total + 2);
        end
    endtask

    initial begin
        RST            = 1'b0;
        START          = 1'b0;
        DATA_IN_ENABLE = 1'b0;
        NEXT_IN        = 1'b0;
        SIZE_I_IN      = '0;
        SIZE_J_IN      = '0;
        DATA_IN        = '0;
        model_out      = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        RST = 1'b1;
        @(posedge CLK);
        #1;

        run(64'd2, 64'd3, 0, 100, 1, 0, 0);
        run(64'd2, 64'd2, 50, 100, 2, 0, 0);
        run(64'd0, 64'd5, 0, 100, 0, 0, 0);
        run(64'd8, 64'd9, 0, 100, 0, 0, 0);
        run(64'h1_0000_0000, 64'h1_0000_0000, 0, 100, 0, 0, 0);
        run(64'd65, 64'd1, 0, 100, 0, 0, 0);
        run(64'd3, 64'd3, 0, 100, 0, 20, 0);
        run(64'd3, 64'd3, 0, 100, 0, 0, 3);
        run(64'd1, 64'd1, 0, 100, 0, 0, 0);
        run(64'd8, 64'd8, 0, 100, 0, 0, 0);
        run(64'd8, 64'd8, 20, 60, 0, 0, 0);
        run(64'd1, 64'd64, 10, 80, 0, 0, 0);
        for (int r = 0; r < 10; r++) begin
            run(64'($urandom_range(1, 9)), 64'($urandom_range(1, 9)), 30, 60, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
